// File: rtl/program_loader.sv
// Front-panel program loader: debounces the panel keys, writes DIP words into
// instruction memory at consecutive addresses, tracks the loaded word count (eom),
// issues run/step/CPU-reset pulses and lets the operator browse loaded words on the LEDs.
// Optional read-back verify is enabled by defining PROGRAM_LOADER_VERIFY_EN; without it
// a write takes a single WRITE cycle and err is tied low.
module program_loader #(
  parameter int unsigned ADDR_W          = 8,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dip,
  input  logic [4:0]        key,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_din,
  output logic              im_we,
  input  logic [DATA_W-1:0] im_dout,
  output logic [ADDR_W-1:0] eom,
  output logic              full,
  output logic              run_start,
  output logic              step,
  output logic              cpu_reset,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] led
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] EOM_MAX = {ADDR_W{1'b1}};

  // Key indices
  localparam int unsigned KeyWrite  = 0;
  localparam int unsigned KeyRun    = 1;
  localparam int unsigned KeyStep   = 2;
  localparam int unsigned KeyClear  = 3;
  localparam int unsigned KeyBrowse = 4;

  typedef enum logic [1:0] {StIdle, StWrite, StRd, StChk} state_t;

  // Debouncer state, one lane per key
  logic [4:0]       sync1_q, sync2_q, level_q, level_d1_q, event_q;
  logic [CNT_W-1:0] cnt_q [5];

  // FSM and datapath state
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] eom_q, eom_d;
  logic              full_q, full_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] led_q, led_d;

  logic [ADDR_W:0]   ptr_inc;
  logic [ADDR_W-1:0] eom_inc;

  assign ptr_inc = {1'b0, ptr_q} + (ADDR_W + 1)'(1);
  assign eom_inc = eom_q + ADDR_W'(1);

  // Synchronize, debounce and edge-detect every key
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      level_d1_q <= '0;
      event_q    <= '0;
      for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q    <= key;
      sync2_q    <= sync1_q;
      level_d1_q <= level_q;
      event_q    <= level_q & ~level_d1_q;
      for (int k = 0; k < 5; k++) begin
        if (sync2_q[k] == level_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          cnt_q[k]   <= '0;
          level_q[k] <= sync2_q[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

`ifdef PROGRAM_LOADER_VERIFY_EN
  logic err_q, err_d;
`endif

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      eom_q   <= '0;
      full_q  <= 1'b0;
      ptr_q   <= '0;
      word_q  <= '0;
      led_q   <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      eom_q   <= eom_d;
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      led_q   <= led_d;
`ifdef PROGRAM_LOADER_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, event arbitration and memory-port outputs
  always_comb begin
    state_d   = state_q;
    eom_d     = eom_q;
    full_d    = full_q;
    ptr_d     = ptr_q;
    word_d    = word_q;
    led_d     = led_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
    err_d     = err_q;
`endif
    im_addr   = eom_q;
    im_we     = 1'b0;
    run_start = 1'b0;
    step      = 1'b0;
    cpu_reset = 1'b0;

    unique case (state_q)
      StIdle: begin
        im_addr = ptr_q;
        led_d   = im_dout;
        // One event per cycle by priority; lower-priority events are dropped
        if (event_q[KeyClear]) begin
          eom_d     = '0;
          ptr_d     = '0;
          full_d    = 1'b0;
          cpu_reset = 1'b1;
`ifdef PROGRAM_LOADER_VERIFY_EN
          err_d     = 1'b0;
`endif
        end else if (event_q[KeyWrite]) begin
          if (!full_q) begin
            word_d  = dip;
            state_d = StWrite;
          end
        end else if (event_q[KeyBrowse]) begin
          if (eom_q != '0) begin
            ptr_d = (ptr_inc >= {1'b0, eom_q}) ? '0 : ptr_inc[ADDR_W-1:0];
          end
        end else if (event_q[KeyRun]) begin
          run_start = (eom_q != '0);
        end else if (event_q[KeyStep]) begin
          step = 1'b1;
        end
      end
      StWrite: begin
        im_we = 1'b1;
`ifdef PROGRAM_LOADER_VERIFY_EN
        state_d = StRd;
`else
        eom_d   = eom_inc;
        full_d  = (eom_inc == EOM_MAX);
        ptr_d   = eom_q;
        state_d = StIdle;
`endif
      end
`ifdef PROGRAM_LOADER_VERIFY_EN
      // Address stays on eom so the written word comes back during StChk
      StRd: begin
        state_d = StChk;
      end
      StChk: begin
        if (im_dout != word_q) err_d = 1'b1;
        eom_d   = eom_inc;
        full_d  = (eom_inc == EOM_MAX);
        ptr_d   = eom_q;
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign im_din = word_q;
  assign eom    = eom_q;
  assign full   = full_q;
  assign busy   = (state_q != StIdle);
  assign led    = led_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader (ADDR_W=3, DEBOUNCE_CYCLES=4). A table of key
// presses drives the main checks; expected memory writes go into a scoreboard queue that a
// negedge monitor drains whenever im_we is seen. Hand-written sequences cover reset during
// a write, a step arriving while busy, read-back verify faults and the full boundary.
module tb_program_loader;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;
`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dip;
  logic [4:0]    key;
  logic [AW-1:0] im_addr;
  logic [DW-1:0] im_din;
  logic          im_we;
  logic [DW-1:0] im_dout;
  logic [AW-1:0] eom;
  logic          full;
  logic          run_start;
  logic          step;
  logic          cpu_reset;
  logic          busy;
  logic          err;
  logic [DW-1:0] led;

  program_loader #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dip      (dip),
    .key      (key),
    .im_addr  (im_addr),
    .im_din   (im_din),
    .im_we    (im_we),
    .im_dout  (im_dout),
    .eom      (eom),
    .full     (full),
    .run_start(run_start),
    .step     (step),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .err      (err),
    .led      (led)
  );

  always #5 clk = ~clk;

  // Instruction memory model: synchronous read, optional corruption of address 0 readback
  logic [DW-1:0] mem [8];
  logic          fault;
  always @(posedge clk) begin
    if (im_we) mem[im_addr] <= im_din;
    im_dout <= (fault && im_addr == '0) ? 16'hFFFF : mem[im_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected writes {addr, data}, plus pulse counters
  logic [AW+DW-1:0] exp_q [$];
  int w_cnt = 0, run_cnt = 0, step_cnt = 0, rst_cnt = 0;

  always @(negedge clk) begin
    if (im_we) begin
      w_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, im_addr}, 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", im_addr, e[AW+DW-1:DW]);
        chk("wr_data", im_din, e[DW-1:0]);
      end
    end
    if (run_start) run_cnt++;
    if (step) step_cnt++;
    if (cpu_reset) rst_cnt++;
  end

  task automatic press(input logic [4:0] k, input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    dip = d;
    key = k;
    repeat (hold) @(negedge clk);
    key = '0;
    repeat (16) @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]    key;
    logic [DW-1:0] dip;
    int            hold;
    bit            wr;
    logic [AW-1:0] waddr;
    logic [AW-1:0] eom;
    bit            full;
    logic [AW-1:0] ptr;
    bit            chk_led;
    logic [DW-1:0] led;
    int            runs;
    int            steps;
    int            rsts;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    int w0, r0, s0, c0;
    bit found;

    //             key       dip       hold wr addr eom full ptr cl led     run stp rst
    vecs[0]  = '{5'b00001, 16'h1234, 3,  0, 3'd0, 3'd0, 0, 3'd0, 0, 16'h0,    0, 0, 0};
    vecs[1]  = '{5'b00001, 16'h1234, 10, 1, 3'd0, 3'd1, 0, 3'd0, 0, 16'h0,    0, 0, 0};
    vecs[2]  = '{5'b00001, 16'hABCD, 10, 1, 3'd1, 3'd2, 0, 3'd1, 0, 16'h0,    0, 0, 0};
    vecs[3]  = '{5'b00001, 16'h0F0F, 10, 1, 3'd2, 3'd3, 0, 3'd2, 0, 16'h0,    0, 0, 0};
    vecs[4]  = '{5'b00010, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd2, 0, 16'h0,    1, 0, 0};
    vecs[5]  = '{5'b10000, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd0, 1, 16'h1234, 0, 0, 0};
    vecs[6]  = '{5'b10000, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd1, 1, 16'hABCD, 0, 0, 0};
    vecs[7]  = '{5'b10000, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd2, 1, 16'h0F0F, 0, 0, 0};
    vecs[8]  = '{5'b10000, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd0, 1, 16'h1234, 0, 0, 0};
    vecs[9]  = '{5'b00100, 16'h0,    10, 0, 3'd0, 3'd3, 0, 3'd0, 0, 16'h0,    0, 1, 0};
    vecs[10] = '{5'b01000, 16'h0,    10, 0, 3'd0, 3'd0, 0, 3'd0, 0, 16'h0,    0, 0, 1};
    vecs[11] = '{5'b10000, 16'h0,    10, 0, 3'd0, 3'd0, 0, 3'd0, 0, 16'h0,    0, 0, 0};
    vecs[12] = '{5'b00010, 16'h0,    10, 0, 3'd0, 3'd0, 0, 3'd0, 0, 16'h0,    0, 0, 0};
    vecs[13] = '{5'b01001, 16'h7777, 10, 0, 3'd0, 3'd0, 0, 3'd0, 0, 16'h0,    0, 0, 1};
    vecs[14] = '{5'b00001, 16'h4242, 10, 1, 3'd0, 3'd1, 0, 3'd0, 0, 16'h0,    0, 0, 0};

    for (int i = 0; i < 8; i++) mem[i] = '0;
    fault = 1'b0;
    rst = 1'b1;
    key = '0;
    dip = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_din", im_din, 0);
    chk("rst_eom", eom, 0);
    chk("rst_full", full, 0);
    chk("rst_run", run_start, 0);
    chk("rst_step", step, 0);
    chk("rst_cpu_reset", cpu_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_led", led, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a write is in flight (in RD with verify, in WRITE without)
    dip = 16'hC3C3;
    key = 5'b00001;
    exp_q.push_back({3'd0, 16'hC3C3});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1'b1;
    end
    chk("midrst_busy_seen", found, 1);
    if (VERIFY) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key = '0;
    repeat (8) @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_eom", eom, 0);
    chk("midrst_full", full, 0);

    // Table-driven key presses
    for (int i = 0; i < NV; i++) begin
      w0 = w_cnt;
      r0 = run_cnt;
      s0 = step_cnt;
      c0 = rst_cnt;
      if (vecs[i].wr) exp_q.push_back({vecs[i].waddr, vecs[i].dip});
      press(vecs[i].key, vecs[i].dip, vecs[i].hold);
      chk($sformatf("v%0d_writes", i), w_cnt - w0, vecs[i].wr ? 1 : 0);
      chk($sformatf("v%0d_eom", i), eom, vecs[i].eom);
      chk($sformatf("v%0d_full", i), full, vecs[i].full);
      chk($sformatf("v%0d_ptr", i), im_addr, vecs[i].ptr);
      chk($sformatf("v%0d_runs", i), run_cnt - r0, vecs[i].runs);
      chk($sformatf("v%0d_steps", i), step_cnt - s0, vecs[i].steps);
      chk($sformatf("v%0d_cpu_rst", i), rst_cnt - c0, vecs[i].rsts);
      chk($sformatf("v%0d_err", i), err, 0);
      if (vecs[i].chk_led) chk($sformatf("v%0d_led", i), led, vecs[i].led);
    end

    // Step event arriving one cycle after a write event lands in WRITE and is dropped
    w0 = w_cnt;
    s0 = step_cnt;
    exp_q.push_back({3'd1, 16'h5A5A});
    @(negedge clk);
    dip = 16'h5A5A;
    key = 5'b00001;
    @(negedge clk);
    key = 5'b00101;
    repeat (10) @(negedge clk);
    key = '0;
    repeat (16) @(negedge clk);
    chk("busy_step_dropped", step_cnt - s0, 0);
    chk("busy_step_write", w_cnt - w0, 1);
    chk("busy_step_eom", eom, 2);

    // Read-back fault on address 0
    press(5'b01000, 16'h0, 10);
    fault = 1'b1;
    exp_q.push_back({3'd0, 16'h1111});
    press(5'b00001, 16'h1111, 10);
    fault = 1'b0;
    chk("fault_err_set", err, VERIFY);
    exp_q.push_back({3'd1, 16'h2222});
    press(5'b00001, 16'h2222, 10);
    chk("fault_err_sticky", err, VERIFY);
    chk("fault_eom", eom, 2);
    c0 = rst_cnt;
    press(5'b01000, 16'h0, 10);
    chk("fault_clr_err", err, 0);
    chk("fault_clr_eom", eom, 0);
    chk("fault_clr_pulse", rst_cnt - c0, 1);

    // Fill to capacity, then one more write must be ignored
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({3'(i), 16'h1000 + 16'(i)});
      press(5'b00001, 16'h1000 + 16'(i), 10);
      if (i == 5) chk("fill6_full", full, 0);
    end
    chk("fill_eom", eom, 7);
    chk("fill_full", full, 1);
    w0 = w_cnt;
    press(5'b00001, 16'hDEAD, 10);
    chk("full_no_write", w_cnt - w0, 0);
    chk("full_eom_hold", eom, 7);
    chk("full_hold", full, 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Front-panel program loader: the writing side of the instruction-memory load interface that the processor core reads from.
- Debounces the raw keys and writes DIP words into instruction memory at consecutive addresses, with optional read-back verify.
- Tracks the end-of-memory count `eom` and issues run, step and CPU-reset pulses to the core.
- Lets the operator browse loaded words on the LEDs.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity is 2^ADDR_W-1 words.
- DATA_W, 16, instruction word width (equals DIP width).
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples needed to accept a key level.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous active-high reset.
- dip, input, DATA_W, word to load.
- key, input, 5, raw asynchronous keys: [0] write, [1] run, [2] step, [3] clear, [4] browse.
- im_addr, output, ADDR_W, instruction-memory address.
- im_din, output, DATA_W, instruction-memory write data.
- im_we, output, 1, instruction-memory write enable.
- im_dout, input, DATA_W, instruction-memory read data; synchronous read, 1-cycle latency.
- eom, output, ADDR_W, number of words loaded.
- full, output, 1, high when eom == 2^ADDR_W-1.
- run_start, output, 1, one-cycle pulse.
- step, output, 1, one-cycle pulse.
- cpu_reset, output, 1, one-cycle pulse.
- busy, output, 1, high when the FSM is not in IDLE.
- err, output, 1, sticky verify mismatch.
- led, output, DATA_W, registered browse display.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; browse pointer 0; debouncers hold 0 and their counters are cleared.
- Per key:
  - Two-flop synchronizer feeds a counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples differing from the current level; the counter resets on any sample equal to the current level.
  - Rising edge of the debounced level gives a one-cycle press event.
  - Total latency from raw edge to event is DEBOUNCE_CYCLES+3 cycles.
- Events are accepted only in IDLE; events arriving while busy are dropped, not queued.
- Simultaneous events: one per cycle by priority clear > write > browse > run > step; the rest are dropped.
- FSM states: IDLE, WRITE, RD, CHK.
- IDLE:
  - im_we=0; im_addr = browse pointer.
  - led <= im_dout every cycle.
- Clear event:
  - eom<=0, pointer<=0, err<=0, full<=0.
  - cpu_reset=1 for one cycle; remain in IDLE.
- Write event:
  - If full, ignore and stay in IDLE.
  - Otherwise latch dip, then go to WRITE.
- WRITE (1 cycle):
  - im_addr=eom, im_din=latched word, im_we=1, busy=1.
  - Next state RD.
- RD (1 cycle):
  - im_we=0, im_addr held at eom.
  - Next state CHK.
- CHK (1 cycle):
  - If im_dout != latched word, set err.
  - eom<=eom+1; full<=(eom+1 == 2^ADDR_W-1); pointer<=eom.
  - Next state IDLE.
  - Write-event to next-IDLE latency is 3 cycles.
- Browse event:
  - If eom==0, pointer stays 0.
  - Otherwise pointer <= (pointer+1 >= eom) ? 0 : pointer+1.
- Run event: run_start=1 for one cycle, only if eom != 0; otherwise ignored.
- Step event: step=1 for one cycle, unconditionally.
- eom never wraps; it saturates at 2^ADDR_W-1 via the full check.
- rst mid-operation (any state) returns to IDLE with the reset values; any write in progress is abandoned and eom is not incremented.
- err is cleared only by rst or a clear event.

Optional Feature:
- Macro: PROGRAM_LOADER_VERIFY_EN.
- Defined: FSM runs WRITE -> RD -> CHK as above; err is functional.
- Undefined:
  - RD and CHK are removed; WRITE goes directly to IDLE.
  - eom, full and pointer update at the end of WRITE; write latency is 1 cycle.
  - err is tied 0.

Test Plan:
- DEBOUNCE_CYCLES=4 in all tests.
- Glitch filtering: key[0] high for 3 cycles then low -> no im_we, eom stays 0. Held 10 cycles -> exactly one im_we with im_addr=0.
- Load sequence: dip=16'h1234, then 16'hABCD, then 16'h0F0F, each with a key[0] press, memory model echoes correctly -> three writes at addresses 0,1,2; eom=3; err=0. Pressing key[1] then gives a single run_start pulse.
- Verify fault (VERIFY_EN): memory model returns 16'hFFFF on readback of address 0 -> err=1 after CHK and stays 1; after key[3], err=0, eom=0, one cycle of cpu_reset.
- Full boundary with ADDR_W=3: 7 writes -> eom=7, full=1. 8th key[0] press -> no im_we, eom remains 7.
- Browse wrap with eom=3 and pointer=2: key[4] press -> pointer=0, led shows word at address 0 one cycle after the address is presented. With eom=0, key[4] press -> pointer stays 0.
- Priority and busy rules:
  - key[3] and key[0] debounced on the same cycle -> only clear occurs, no im_we.
  - key[2] pressed during WRITE -> no step pulse.
  - rst asserted in RD -> FSM returns to IDLE, eom unchanged.
